axi_rd_slave: RTL and testbench
===============================

// Module: axi_rd_slave
// PURPOSE
//  AXI3-style read-only slave (responder) backing the ICache refill master: accepts AR bursts, fetches
//  words from a 1-cycle synchronous-read memory port, returns R beats with full rready backpressure.
//  Sits behind the instruction-side interconnect as boot ROM / instruction RAM; ID echoed, one burst at a time.
// PARAMETERS
//  MEM_AW     12             word-address width of backing memory (4*2^MEM_AW bytes)
//  BASE_ADDR  32'h1FC0_0000  byte base address of the window (aligned to window size)
//  FIRST_LAT  0              extra idle cycles inserted before the first beat (0..15)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  s_arid      in   4       read ID
//  s_araddr    in   32      byte start address
//  s_arlen     in   4       beats-1
//  s_arsize    in   3       must be 3'b010
//  s_arburst   in   2       00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  s_arvalid   in   1       AR valid
//  s_arready   out  1       AR ready
//  s_rid       out  4       echo of latched arid
//  s_rdata     out  32      read data
//  s_rresp     out  2       00 OKAY, 10 SLVERR, 11 DECERR
//  s_rlast     out  1       final beat
//  s_rvalid    out  1       R valid
//  s_rready    in   1       R ready
//  mem_en      out  1       memory read enable
//  mem_addr    out  MEM_AW  memory word address
//  mem_rdata   in   32      data for the mem_en issued in the previous cycle
// BEHAVIOUR
//  Reset: all outputs 0; s_arready registered, rises on first clk edge after rst release.
//  Reset mid-burst: burst abandoned, rvalid/rlast/mem_en drop at once, FSM to IDLE.
//  FSM IDLE: arready=1; on arvalid&&arready latch id/addr/len/burst/size, arready=0, go LAT (FIRST_LAT>0) or BURST.
//  LAT: count FIRST_LAT cycles, then BURST.
//  BURST: issue mem reads into 2-entry output buffer; read issued only if
//   (buffered + in-flight) < 2 and beats issued <= len.
//   Sustains 1 beat/cycle with rready=1.
//  Latency: AR handshake in cycle T -> mem_en in T+1 -> first rvalid in T+2+FIRST_LAT.
//  R channel: rvalid held until rready; rdata/rresp/rlast/rid stable while rvalid&&!rready.
//  rlast on beat number len only. Last handshake -> IDLE; arready=1 next cycle.
//  Address gen: FIXED constant; INCR +4 per beat, 32-bit wrap, no 4KB check.
//   WRAP wraps within (len+1)*4-byte aligned region.
//  Errors: arsize!=010, burst=11, or WRAP with len not in {1,3,7,15}:
//   all len+1 beats SLVERR, rdata 0, no mem_en.
//  mem_addr = beat_addr[MEM_AW+1:2]; araddr[1:0] ignored.
// CONFIGURATION
//  AXIS_RANGE_CHECK_EN defined: beats outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AW) return DECERR, rdata 0, no mem_en.
//   Checked per beat: an INCR burst can cross out mid-burst.
//  Undefined: no range check, address aliases on low bits, rresp OKAY (except SLVERR cases).
// TESTING
//  INCR arlen=F araddr=BASE arid=1, rready=1 -> 16 back-to-back beats mem[0..15], rid=1, rresp=0, rlast on beat 16 only.
//  Same burst, rready toggles 1/0 each cycle -> 16 beats, no loss/dup, data stable during stall cycles.
//  WRAP arlen=3 araddr=BASE+8 -> words 2,3,0,1; rlast on 4th.
//  FIXED arlen=3 BASE+4 -> word 1 x4; arburst=11 arlen=1 -> 2 beats SLVERR, mem_en never high.
//  araddr=BASE-4 INCR arlen=1: macro on -> beats DECERR,OKAY(word0); off -> OKAY, words 2^MEM_AW-1 and 0.
//  rst pulse at beat 5 of 16 -> rvalid=0 immediately; arready 1 one edge after release; next burst correct.

Source files
------------

// File: rtl/axi_rd_slave.sv
// AXI3-style read-only slave for ICache refill: one AR burst at a time, 1-cycle sync memory, 2-deep R buffer.
// Optional AXIS_RANGE_CHECK_EN: beats outside the BASE_ADDR window return DECERR without touching memory.
//
// state    | meaning
// ST_IDLE  | arready high, waiting for an AR handshake
// ST_LAT   | FIRST_LAT idle cycles before the first memory read
// ST_BURST | issuing reads / error beats and draining the R buffer
module axi_rd_slave #(
   parameter int          MEM_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
   parameter int          FIRST_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        s_arid,
   input  logic [31:0]       s_araddr,
   input  logic [3:0]        s_arlen,
   input  logic [2:0]        s_arsize,
   input  logic [1:0]        s_arburst,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [3:0]        s_rid,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_LAT, ST_BURST} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [3:0] LAT_INIT    = (FIRST_LAT > 0) ? 4'(FIRST_LAT - 1) : 4'd0;

   state_t            state_q, state_d;
   logic              arready_q, arready_d;
   logic [3:0]        id_q, id_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        len_q, len_d;
   logic [1:0]        burst_q, burst_d;
   logic              err_q, err_d;
   logic [3:0]        lat_q, lat_d;
   logic [4:0]        iss_q, iss_d;
   logic              pend_q, pend_d;
   logic [1:0]        pend_resp_q, pend_resp_d;
   logic              pend_last_q, pend_last_d;
   logic [1:0][31:0]  b_data_q, b_data_d;
   logic [1:0][1:0]   b_resp_q, b_resp_d;
   logic [1:0]        b_last_q, b_last_d;
   logic [1:0]        cnt_q, cnt_d;

   logic        head_valid, head_last, pop, issue, ar_err, in_range;
   logic [31:0] pend_data, head_data, next_addr, wrap_mask;
   logic [1:0]  head_resp, beat_resp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         arready_q   <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         burst_q     <= '0;
         err_q       <= 1'b0;
         lat_q       <= '0;
         iss_q       <= '0;
         pend_q      <= 1'b0;
         pend_resp_q <= '0;
         pend_last_q <= 1'b0;
         b_data_q    <= '0;
         b_resp_q    <= '0;
         b_last_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         arready_q   <= arready_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         lat_q       <= lat_d;
         iss_q       <= iss_d;
         pend_q      <= pend_d;
         pend_resp_q <= pend_resp_d;
         pend_last_q <= pend_last_d;
         b_data_q    <= b_data_d;
         b_resp_q    <= b_resp_d;
         b_last_q    <= b_last_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      burst_d     = burst_q;
      err_d       = err_q;
      lat_d       = lat_q;
      iss_d       = iss_q;
      pend_d      = 1'b0;
      pend_resp_d = pend_resp_q;
      pend_last_d = pend_last_q;
      b_data_d    = b_data_q;
      b_resp_d    = b_resp_q;
      b_last_d    = b_last_q;
      cnt_d       = cnt_q;

      // A beat read last cycle is presented straight from mem_rdata when the buffer is empty
      pend_data  = (pend_resp_q == RESP_OKAY) ? mem_rdata : 32'd0;
      head_valid = (cnt_q != 2'd0) || pend_q;
      head_data  = (cnt_q != 2'd0) ? b_data_q[0] : pend_data;
      head_resp  = (cnt_q != 2'd0) ? b_resp_q[0] : pend_resp_q;
      head_last  = (cnt_q != 2'd0) ? b_last_q[0] : pend_last_q;
      pop        = head_valid && s_rready;

      if (pop && (cnt_q != 2'd0)) begin
         b_data_d[0] = b_data_q[1];
         b_resp_d[0] = b_resp_q[1];
         b_last_d[0] = b_last_q[1];
         cnt_d       = cnt_q - 2'd1;
      end
      if (pend_q && !(pop && (cnt_q == 2'd0))) begin
         b_data_d[cnt_d[0]] = pend_data;
         b_resp_d[cnt_d[0]] = pend_resp_q;
         b_last_d[cnt_d[0]] = pend_last_q;
         cnt_d              = cnt_d + 2'd1;
      end

`ifdef AXIS_RANGE_CHECK_EN
      in_range = (addr_q[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
`else
      in_range = 1'b1;
`endif
      beat_resp = err_q ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);

      wrap_mask = {26'd0, len_q, 2'b11};
      case (burst_q)
         2'b00:   next_addr = addr_q;
         2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
         default: next_addr = addr_q + 32'd4;
      endcase

      // Occupancy counted after this cycle's pop/push so a full-rate stream never bubbles
      issue  = (state_q == ST_BURST) && (iss_q <= {1'b0, len_q}) && (cnt_d < 2'd2);
      mem_en = issue && (beat_resp == RESP_OKAY);
      if (issue) begin
         pend_d      = 1'b1;
         pend_resp_d = beat_resp;
         pend_last_d = (iss_q[3:0] == len_q);
         iss_d       = iss_q + 5'd1;
         addr_d      = next_addr;
      end

      ar_err = (s_arsize != 3'b010) || (s_arburst == 2'b11) ||
               ((s_arburst == 2'b10) && !((s_arlen == 4'd1) || (s_arlen == 4'd3) ||
                                          (s_arlen == 4'd7) || (s_arlen == 4'd15)));

      case (state_q)
         ST_IDLE: begin
            if (s_arvalid && arready_q) begin
               id_d    = s_arid;
               addr_d  = s_araddr;
               len_d   = s_arlen;
               burst_d = s_arburst;
               err_d   = ar_err;
               iss_d   = '0;
               lat_d   = LAT_INIT;
               state_d = (FIRST_LAT > 0) ? ST_LAT : ST_BURST;
            end
         end
         ST_LAT: begin
            if (lat_q == 4'd0) state_d = ST_BURST;
            else               lat_d   = lat_q - 4'd1;
         end
         ST_BURST: begin
            if (pop && head_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      arready_d = (state_d == ST_IDLE);
   end

   assign s_arready = arready_q;
   assign s_rvalid  = head_valid;
   assign s_rdata   = head_valid ? head_data : 32'd0;
   assign s_rresp   = head_valid ? head_resp : 2'b00;
   assign s_rlast   = head_valid && head_last;
   assign s_rid     = id_q;
   // Window offset; BASE_ADDR is window-aligned so this equals the low word-address bits
   assign mem_addr  = addr_q[MEM_AW+1:2] - BASE_ADDR[MEM_AW+1:2];

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: table of AR bursts with hand-listed expected words/responses,
// plus reset-at-start and reset-mid-burst sequences. Honours AXIS_RANGE_CHECK_EN for expectations.
module tb_axi_rd_slave;

   localparam logic [31:0] BASE = 32'h1FC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  s_arid = '0;
   logic [31:0] s_araddr = '0;
   logic [3:0]  s_arlen = '0;
   logic [2:0]  s_arsize = 3'b010;
   logic [1:0]  s_arburst = 2'b01;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [3:0]  s_rid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic        s_rvalid;
   logic        s_rready = 1'b1;
   logic        mem_en;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;
   int mem_en_cnt = 0;

   axi_rd_slave dut (
      .clk(clk), .rst(rst),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input int i);
      return 32'hD00D_0000 | 32'(i);
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata  <= data_of(int'(mem_addr));
         mem_en_cnt <= mem_en_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      bit          stall;
      bit          no_mem;
      int          w[16];
      logic [1:0]  r[16];
   } vec_t;

   vec_t vecs[10];

   task automatic drive_ar(input vec_t v);
      s_arid    = v.id;
      s_araddr  = v.addr;
      s_arlen   = v.len;
      s_arsize  = v.size;
      s_arburst = v.burst;
      s_arvalid = 1'b1;
   endtask

   task automatic run_burst(input int vi, input vec_t v);
      int k, c, beat, en_start;
      logic [38:0] prev, cur, exp;
      bit have_prev;
      en_start = mem_en_cnt;
      s_rready = 1'b1;
      drive_ar(v);
      k = 0;
      while (!s_arready && k < 50) begin
         @(posedge clk); @(negedge clk); k++;
      end
      chk($sformatf("v%0d ar_wait", vi), 64'(s_arready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0;
      chk($sformatf("v%0d mem_en_t1", vi), 64'(mem_en), 64'(v.r[0] == 2'b00));
      chk($sformatf("v%0d rvalid_t1", vi), 64'(s_rvalid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      beat = 0; c = 0; have_prev = 0; prev = '0;
      while (beat <= int'(v.len) && c < 200) begin
         s_rready = v.stall ? (c % 2 == 0) : 1'b1;
         cur = {s_rid, s_rresp, s_rlast, s_rdata};
         if (c == 0) chk($sformatf("v%0d first_rvalid", vi), 64'(s_rvalid), 64'd1);
         else if (!v.stall) chk($sformatf("v%0d b2b c%0d", vi, c), 64'(s_rvalid), 64'd1);
         if (have_prev && s_rvalid) chk($sformatf("v%0d stall_hold c%0d", vi, c), 64'(cur), 64'(prev));
         if (s_rvalid && s_rready) begin
            exp = {v.id, v.r[beat], beat == int'(v.len),
                   (v.r[beat] == 2'b00) ? data_of(v.w[beat]) : 32'd0};
            chk($sformatf("v%0d beat%0d {rid,rresp,rlast,rdata}", vi, beat), 64'(cur), 64'(exp));
            beat++;
            have_prev = 0;
         end else if (s_rvalid) begin
            prev = cur;
            have_prev = 1;
         end
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      chk($sformatf("v%0d beats_done", vi), 64'(beat), 64'(int'(v.len) + 1));
      chk($sformatf("v%0d arready_after", vi), 64'(s_arready), 64'd1);
      chk($sformatf("v%0d rvalid_after", vi), 64'(s_rvalid), 64'd0);
      if (v.no_mem) chk($sformatf("v%0d mem_en_count", vi), 64'(mem_en_cnt - en_start), 64'd0);
      s_rready = 1'b1;
   endtask

   initial begin
      int k, acc;
      for (int i = 0; i < 10; i++) begin
         vecs[i].size = 3'b010; vecs[i].stall = 0; vecs[i].no_mem = 0;
         for (int j = 0; j < 16; j++) begin vecs[i].w[j] = 0; vecs[i].r[j] = 2'b00; end
      end
      // 0/1: INCR 16 beats from BASE, full rate then with rready toggling
      vecs[0].id = 4'd1; vecs[0].addr = BASE; vecs[0].len = 4'hF; vecs[0].burst = 2'b01;
      for (int j = 0; j < 16; j++) vecs[0].w[j] = j;
      vecs[1] = vecs[0]; vecs[1].stall = 1;
      // 2: WRAP len3 at BASE+8 -> 2,3,0,1
      vecs[2].id = 4'd3; vecs[2].addr = BASE + 32'd8; vecs[2].len = 4'd3; vecs[2].burst = 2'b10;
      vecs[2].w[0] = 2; vecs[2].w[1] = 3; vecs[2].w[2] = 0; vecs[2].w[3] = 1;
      // 3: FIXED len3 at BASE+4 -> word 1 x4
      vecs[3].id = 4'd4; vecs[3].addr = BASE + 32'd4; vecs[3].len = 4'd3; vecs[3].burst = 2'b00;
      for (int j = 0; j < 4; j++) vecs[3].w[j] = 1;
      // 4: reserved burst type -> SLVERR x2
      vecs[4].id = 4'd5; vecs[4].addr = BASE; vecs[4].len = 4'd1; vecs[4].burst = 2'b11; vecs[4].no_mem = 1;
      vecs[4].r[0] = 2'b10; vecs[4].r[1] = 2'b10;
      // 5: bad arsize -> SLVERR x1
      vecs[5].id = 4'd6; vecs[5].addr = BASE; vecs[5].len = 4'd0; vecs[5].burst = 2'b01;
      vecs[5].size = 3'b011; vecs[5].no_mem = 1; vecs[5].r[0] = 2'b10;
      // 6: WRAP with len 2 -> SLVERR x3
      vecs[6].id = 4'd7; vecs[6].addr = BASE; vecs[6].len = 4'd2; vecs[6].burst = 2'b10; vecs[6].no_mem = 1;
      for (int j = 0; j < 3; j++) vecs[6].r[j] = 2'b10;
      // 7: INCR from BASE-4, len1
      vecs[7].id = 4'd8; vecs[7].addr = BASE - 32'd4; vecs[7].len = 4'd1; vecs[7].burst = 2'b01;
`ifdef AXIS_RANGE_CHECK_EN
      vecs[7].r[0] = 2'b11; vecs[7].w[1] = 0;
`else
      vecs[7].w[0] = 4095; vecs[7].w[1] = 0;
`endif
      // 8: WRAP len7 at BASE+0x1C with stalls -> 7,0..6
      vecs[8].id = 4'd9; vecs[8].addr = BASE + 32'h1C; vecs[8].len = 4'd7; vecs[8].burst = 2'b10;
      vecs[8].stall = 1;
      vecs[8].w[0] = 7;
      for (int j = 1; j < 8; j++) vecs[8].w[j] = j - 1;
      // 9: INCR len2 from the last window word
      vecs[9].id = 4'hA; vecs[9].addr = BASE + 32'h3FFC; vecs[9].len = 4'd2; vecs[9].burst = 2'b01;
      vecs[9].w[0] = 4095;
`ifdef AXIS_RANGE_CHECK_EN
      vecs[9].r[1] = 2'b11; vecs[9].r[2] = 2'b11;
`else
      vecs[9].w[1] = 0; vecs[9].w[2] = 1;
`endif

      repeat (3) @(negedge clk);
      chk("reset outputs", 64'({s_arready, s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_en, mem_addr}), 64'd0);
      rst = 1'b0;
      #1;
      chk("arready at release", 64'(s_arready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("arready one edge after release", 64'(s_arready), 64'd1);

      for (int i = 0; i < 10; i++) run_burst(i, vecs[i]);

      // reset while beat 5 of 16 is presented
      s_rready = 1'b1;
      drive_ar(vecs[0]);
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0;
      acc = 0; k = 0;
      while (acc < 4 && k < 50) begin
         if (s_rvalid && s_rready) acc++;
         @(posedge clk); @(negedge clk); k++;
      end
      chk("mid rvalid before rst", 64'(s_rvalid), 64'd1);
      chk("mid rdata before rst", 64'(s_rdata), 64'(data_of(4)));
      rst = 1'b1;
      #1;
      chk("mid rst outputs", 64'({s_rvalid, s_rlast, mem_en, s_arready}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid arready at release", 64'(s_arready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mid arready after release", 64'(s_arready), 64'd1);
      run_burst(10, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
